// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative integer multiply/divide unit with HI/LO result
//                registers. Multiply is shift-add, divide is restoring
//                shift-subtract. Each takes WIDTH cycles of iteration plus
//                one sign-fix cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dInA,
  input  logic [WIDTH-1:0] dInB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] dInHL,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // product sign (mult) or quotient sign (div)
  logic               r_neg_r;     // remainder sign = dividend sign
  logic               r_b_zero;    // divide by zero captured at latch
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;       // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div0;

  // Operand magnitudes and signs, seen only at the latch cycle
  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_signed_op = ~op[0];
  assign w_a_neg     = w_signed_op & dInA[WIDTH-1];
  assign w_b_neg     = w_signed_op & dInB[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (-dInA) : dInA;
  assign w_b_mag     = w_b_neg ? (-dInB) : dInB;

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right with carry.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor, keep the difference if it did not
  // go negative and shift the matching quotient bit in at the bottom.
  logic [WIDTH:0]     w_rem_ext;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_ext  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_ext - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX. A zero divisor yields an all-ones
  // quotient; the remainder is then the dividend magnitude, which the
  // dividend-sign correction turns back into the original dividend.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo_fix  = r_b_zero ? {WIDTH{1'b1}} : (r_neg_q ? (-w_quo) : w_quo);
  assign w_rem_fix  = r_neg_r ? (-w_rem) : w_rem;

  // Control state machine and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CALC;
            r_cnt   <= {CW{1'b0}};
          end
        end
        CALC: begin
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Operand latch at start, then one datapath iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= {WIDTH{1'b0}};
      r_acc    <= {2*WIDTH{1'b0}};
    end else if ((r_state == IDLE) && start) begin
      r_is_div <= op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b_zero <= (dInB == {WIDTH{1'b0}});
      if (op[1]) begin
        r_opnd <= w_b_mag;
        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
      end else begin
        r_opnd <= w_a_mag;
        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
      end
    end else if (r_state == CALC) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  // Architectural HI/LO, done pulse and sticky divide-by-zero flag.
  // Direct writes only happen in IDLE and lose to a same-cycle start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_done <= 1'b0;
      r_div0 <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == FIX) begin
        r_done <= 1'b1;
        if (r_is_div) begin
          r_hi   <= w_rem_fix;
          r_lo   <= w_quo_fix;
          r_div0 <= r_b_zero;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end else if ((r_state == IDLE) && !start) begin
        if (mthi) begin
          r_hi <= dInHL;
        end
        if (mtlo) begin
          r_lo <= dInHL;
        end
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (WIDTH=32). A timing
//                model with arithmetic reference results is compared with
//                the DUT every cycle, plus hand-computed literal results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dInA = '0;
  logic [W-1:0] dInB = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] dInHL = '0;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dInA(dInA), .dInB(dInB), .mthi(mthi), .mtlo(mtlo), .dInHL(dInHL),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} straight from the arithmetic definition
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: begin
        p = 64'(sa * sb);
      end
      2'b01: begin
        p = ua * ub;
      end
      2'b10: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else begin
          p[63:32] = 32'(ua % ub);
          p[31:0]  = 32'(ua / ub);
        end
      end
    endcase
    return p;
  endfunction

  // Timing model: an accepted op completes WIDTH+1 edges later
  int           m_cnt;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_div0, p_isdiv, p_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_div0 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
          if (p_isdiv) m_div0 <= p_zero;
        end
      end else if (start) begin
        {p_hi, p_lo} <= ref_res(op, dInA, dInB);
        p_isdiv <= op[1];
        p_zero  <= (dInB == '0);
        m_cnt   <= W + 1;
      end else begin
        if (mthi) m_hi <= dInHL;
        if (mtlo) m_lo <= dInHL;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("div0", 64'(div0), 64'(m_div0));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drive a start for one cycle; caller is at a negedge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dInA = a; dInB = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); dInA = $urandom; dInB = $urandom;
  endtask

  // Wait for done (bounded); optionally inject ignored starts/strobes meanwhile.
  // lat counts negedges from start assertion, including the issue cycle.
  task automatic wait_done(input bit garbage, output int lat);
    int n = 0;
    while (!done && n < 60) begin
      if (garbage) begin
        start = 1'($urandom); mthi = 1'($urandom); mtlo = 1'($urandom);
        op = 2'($urandom); dInA = $urandom; dInB = $urandom; dInHL = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    lat = n + 1;
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit garbage, output int lat);
    issue(o, a, b);
    wait_done(garbage, lat);
  endtask

  initial begin
    int lat;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_done_div0", {62'd0, done, div0}, 64'd0);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // MULT -2*3, started in the first cycle out of reset; done 33 edges after E0
    run(2'b00, 32'hFFFF_FFFE, 32'h3, 1'b0, lat);
    chk("mult_lat", 64'(lat), 64'(W + 2));
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_busy_done", 64'(busy), 64'd0);

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0, lat);
    chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);

    run(2'b11, 32'h1234, 32'h0, 1'b0, lat);
    chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    chk("divu_zero_flag", 64'(div0), 64'd1);
    chk("divu_zero_lat", 64'(lat), 64'(W + 2));
    run(2'b00, 32'h3, 32'h4, 1'b0, lat);
    chk("mult_keeps_div0", 64'(div0), 64'd1);
    run(2'b11, 32'd10, 32'd3, 1'b0, lat);
    chk("divu_10_3", {hi, lo}, 64'h0000_0001_0000_0003);
    chk("divu_clear_flag", 64'(div0), 64'd0);

    // Direct HI/LO writes in idle, and a start winning over mthi
    mthi = 1'b1; mtlo = 1'b1; dInHL = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    mthi = 1'b1; dInHL = 32'h1111_1111;
    run(2'b01, 32'd7, 32'd9, 1'b0, lat);
    chk("start_wins", {hi, lo}, 64'd63);

    // Ignored start/mthi during CALC, then back-to-back start on the done cycle
    run(2'b00, 32'hFFFF_FFFF, 32'd5, 1'b1, lat);
    chk("garbage_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
    issue(2'b01, 32'd11, 32'd13);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(1'b0, lat);
    chk("b2b_res", {hi, lo}, 64'd143);

    // Asynchronous reset mid-CALC
    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(2'b01, 32'd5, 32'd6, 1'b0, lat);
    chk("after_rst", {hi, lo}, 64'd30);

    // Randomized traffic; the per-cycle compare does the checking
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        mthi = 1'($urandom); mtlo = 1'($urandom); dInHL = $urandom;
        @(negedge clk);
      end
      mthi = 1'b0; mtlo = 1'b0;
      run(2'($urandom), rnd_opnd(), rnd_opnd(), 1'($urandom), lat);
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
